alu_frame_controller: RTL and testbench

- Sequencer between the UART receiver/transmitter and the shared ALU.
- Collects a 3-byte command frame from UART rx: data A, data B, opcode.
- Commits all three operands to the ALU at once, captures the ALU result and launches one UART tx byte.
- Enforces an inter-byte timeout and reports bytes dropped while a command is in flight.

---
 rtl/alu_frame_controller.sv | 144 ++++++++++++++
 tb/tb_alu_frame_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_frame_controller.sv
// Frame sequencer between UART and ALU: collects A, B and opcode, commits them atomically, then sends the result byte.
// Latency: opcode tick at edge N -> operands at N, result at N+1, o_tx_start during the cycle after N+1.
module alu_frame_controller #(
  parameter int DBIT        = 8,
  parameter int NB_OP       = 6,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx_done_tick,
  input  logic [DBIT-1:0] i_rx_data,
  input  logic            i_tx_done_tick,
  input  logic [DBIT-1:0] i_alu_data_in,
  output logic [DBIT-1:0] o_data_a,
  output logic [DBIT-1:0] o_data_b,
  output logic [NB_OP-1:0] o_operation,
  output logic            o_tx_start,
  output logic [DBIT-1:0] o_data_out,
  output logic            o_busy,
  output logic            o_err_timeout,
  output logic            o_err_overrun
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_B, S_WAIT_OP, S_EXEC, S_SEND, S_WAIT_TX
  } state_t;

  state_t          state_q, state_d;
  logic [DBIT-1:0] shadow_a_q, shadow_a_d;
  logic [DBIT-1:0] shadow_b_q, shadow_b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DBIT-1:0] data_a_q, data_a_d;
  logic [DBIT-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0] op_q, op_d;
  logic [DBIT-1:0] data_out_q, data_out_d;
  logic            tx_start_q, tx_start_d;
  logic            busy_q, busy_d;
  logic            err_to_q, err_to_d;
  logic            err_ov_q, err_ov_d;

  always_comb begin
    state_d    = state_q;
    shadow_a_d = shadow_a_q;
    shadow_b_d = shadow_b_q;
    cnt_d      = cnt_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    data_out_d = data_out_q;
    err_to_d   = 1'b0;
    err_ov_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_rx_done_tick) begin
          shadow_a_d = i_rx_data;
          cnt_d      = '0;
          state_d    = S_WAIT_B;
        end
      end
      S_WAIT_B, S_WAIT_OP: begin
        // A tick on the timeout edge wins over the timeout.
        if (i_rx_done_tick) begin
          cnt_d = '0;
          if (state_q == S_WAIT_B) begin
            shadow_b_d = i_rx_data;
            state_d    = S_WAIT_OP;
          end else begin
            data_a_d = shadow_a_q;
            data_b_d = shadow_b_q;
            op_d     = i_rx_data[NB_OP-1:0];
            state_d  = S_EXEC;
          end
        end else if (cnt_q == CNT_MAX) begin
          err_to_d   = 1'b1;
          cnt_d      = '0;
          shadow_a_d = '0;
          shadow_b_d = '0;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        err_ov_d   = i_rx_done_tick;
        data_out_d = i_alu_data_in;
        state_d    = S_SEND;
      end
      S_SEND: begin
        err_ov_d = i_rx_done_tick;
        state_d  = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        err_ov_d = i_rx_done_tick;
        if (i_tx_done_tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    tx_start_d = (state_d == S_SEND);
    busy_d     = (state_d == S_EXEC) || (state_d == S_SEND) || (state_d == S_WAIT_TX);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      shadow_a_q <= '0;
      shadow_b_q <= '0;
      cnt_q      <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      data_out_q <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      err_to_q   <= 1'b0;
      err_ov_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_a_q <= shadow_a_d;
      shadow_b_q <= shadow_b_d;
      cnt_q      <= cnt_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      data_out_q <= data_out_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      err_to_q   <= err_to_d;
      err_ov_q   <= err_ov_d;
    end
  end

  assign o_data_a      = data_a_q;
  assign o_data_b      = data_b_q;
  assign o_operation   = op_q;
  assign o_tx_start    = tx_start_q;
  assign o_data_out    = data_out_q;
  assign o_busy        = busy_q;
  assign o_err_timeout = err_to_q;
  assign o_err_overrun = err_ov_q;

endmodule

// File: tb/tb_alu_frame_controller.sv
// Bench for alu_frame_controller: directed frames plus randomized frames checked against a transaction-level model.
module tb_alu_frame_controller;
  localparam int T = 16;

  logic       i_clk, i_reset, i_rx_done_tick, i_tx_done_tick;
  logic [7:0] i_rx_data, i_alu_data_in;
  logic [7:0] o_data_a, o_data_b, o_data_out;
  logic [5:0] o_operation;
  logic       o_tx_start, o_busy, o_err_timeout, o_err_overrun;

  alu_frame_controller #(.DBIT(8), .NB_OP(6), .TIMEOUT_CYC(T)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_done_tick(i_rx_done_tick), .i_rx_data(i_rx_data),
    .i_tx_done_tick(i_tx_done_tick), .i_alu_data_in(i_alu_data_in),
    .o_data_a(o_data_a), .o_data_b(o_data_b), .o_operation(o_operation), .o_tx_start(o_tx_start),
    .o_data_out(o_data_out), .o_busy(o_busy), .o_err_timeout(o_err_timeout), .o_err_overrun(o_err_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  localparam logic [5:0] OP_ADD = 6'h20, OP_SUB = 6'h22, OP_AND = 6'h24, OP_OR = 6'h25,
                         OP_XOR = 6'h26, OP_NOR = 6'h27, OP_SRA = 6'h03, OP_SRL = 6'h02;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRA:  return 8'($signed(a) >>> b[2:0]);
      OP_SRL:  return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  assign i_alu_data_in = alu_f(o_data_a, o_data_b, o_operation);

  int n_tests = 0, n_fail = 0;
  // Model: last committed frame and how many pulses of each kind should have been seen.
  logic [7:0] m_a = 0, m_b = 0, m_res = 0;
  logic [5:0] m_op = 0;
  int m_txs = 0, m_to = 0, m_ov = 0;
  int txs_cnt = 0, to_cnt = 0, ov_cnt = 0;

  always @(negedge i_clk) begin
    if (o_tx_start)    txs_cnt++;
    if (o_err_timeout) to_cnt++;
    if (o_err_overrun) ov_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int g);
    repeat (g) cyc();
  endtask

  task automatic rx(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done_tick = 1'b1;
    cyc();
    i_rx_done_tick = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {o_data_a, o_data_b, o_operation, o_tx_start, o_data_out, o_busy,
                   o_err_timeout, o_err_overrun}, 64'd0);
  endtask

  task automatic check_counts(input string tag);
    cyc();
    check_eq({tag, "_txs"}, txs_cnt, m_txs);
    check_eq({tag, "_to"},  to_cnt,  m_to);
    check_eq({tag, "_ov"},  ov_cnt,  m_ov);
  endtask

  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input int g1, input int g2, input int txw, input bit ovr, input bit ovr_done);
    rx(a);
    idle(g1);
    rx(b);
    check_eq("hold_a", o_data_a, m_a);
    check_eq("hold_op", o_operation, m_op);
    idle(g2);
    rx(opb);
    m_a = a; m_b = b; m_op = opb[5:0];
    m_res = alu_f(a, b, opb[5:0]);
    m_txs++;
    check_eq("commit", {o_data_a, o_data_b, o_operation}, {m_a, m_b, m_op});
    check_eq("exec_busy_start", {o_busy, o_tx_start}, 2'b10);
    cyc();
    check_eq("send_start", {o_busy, o_tx_start}, 2'b11);
    check_eq("send_dout", o_data_out, m_res);
    cyc();
    check_eq("waittx_start", {o_busy, o_tx_start}, 2'b10);
    idle(txw);
    if (ovr) begin
      rx(8'hAA);
      m_ov++;
      check_eq("ovr_pulse", {o_err_overrun, o_busy}, 2'b11);
      check_eq("ovr_dout", o_data_out, m_res);
    end
    i_tx_done_tick = 1'b1;
    if (ovr_done) begin
      i_rx_data = 8'h55;
      i_rx_done_tick = 1'b1;
      m_ov++;
    end
    cyc();
    i_tx_done_tick = 1'b0;
    i_rx_done_tick = 1'b0;
    check_eq("done_busy_ovr", {o_busy, o_err_overrun}, {1'b0, ovr_done});
    check_eq("idle_dout", o_data_out, m_res);
  endtask

  task automatic abort_frame(input int nb);
    rx(8'($urandom));
    if (nb == 2) begin
      idle($urandom_range(0, T - 1));
      rx(8'($urandom));
    end
    idle(T - 1);
    check_eq("to_early", {o_err_timeout, o_busy}, 2'b00);
    cyc();
    m_to++;
    check_eq("to_pulse", {o_err_timeout, o_busy}, 2'b10);
    check_eq("to_keep", {o_data_a, o_data_b, o_operation}, {m_a, m_b, m_op});
    cyc();
    check_eq("to_single", o_err_timeout, 1'b0);
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_op = 0; m_res = 0;
  endtask

  task automatic release_reset();
    @(posedge i_clk);
    #5 i_reset = 1'b1;
    cyc();
  endtask

  logic [5:0] ops [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};

  initial begin
    i_reset = 1'b0; i_rx_done_tick = 1'b0; i_tx_done_tick = 1'b0; i_rx_data = 8'h00;
    #1 check_all_zero("rst_async");
    idle(3);
    release_reset();
    check_all_zero("rst_release");

    do_frame(8'h96, 8'h69, 8'h25, 2, 3, 1, 0, 0);
    check_eq("or_res", {o_operation, o_data_out}, {6'b100101, 8'hFF});
    check_counts("or");

    do_frame(8'd21, 8'd34, 8'hE2, 0, 0, 0, 0, 0);
    check_eq("sub_res", {o_operation, o_data_out}, {6'b100010, 8'hF3});

    rx(8'h10);
    idle(T - 1);
    check_eq("to16_early", o_err_timeout, 1'b0);
    cyc();
    m_to++;
    check_eq("to16_pulse", {o_err_timeout, o_busy, o_data_a}, {2'b10, 8'd21});
    do_frame(8'd5, 8'd3, {2'b00, OP_ADD}, 1, 1, 0, 0, 0);
    check_eq("add_res", o_data_out, 8'h08);
    check_counts("to16");

    do_frame(8'h12, 8'h34, {2'b11, OP_XOR}, 0, 0, 2, 1, 0);
    do_frame(8'h0F, 8'hF0, {2'b00, OP_AND}, 0, 0, 0, 0, 0);
    check_eq("after_ovr_a", o_data_a, 8'h0F);
    do_frame(8'h81, 8'h02, {2'b01, OP_SRA}, 0, 0, 0, 0, 1);
    do_frame(8'h44, 8'h22, {2'b10, OP_SUB}, T - 1, T - 1, 0, 0, 0);
    check_counts("simul");

    i_tx_done_tick = 1'b1;
    cyc();
    i_tx_done_tick = 1'b0;
    cyc();
    check_eq("stray_done", o_busy, 1'b0);

    rx(8'h01); rx(8'h02);
    #2 i_reset = 1'b0;
    #1 check_all_zero("rst_waitop");
    model_reset();
    release_reset();
    idle(T + 4);
    check_all_zero("rst_waitop_after");

    rx(8'h07); rx(8'h09); rx({2'b00, OP_ADD});
    cyc();
    check_eq("pre_rst_send", o_tx_start, 1'b1);
    #2 i_reset = 1'b0;
    #1 check_all_zero("rst_send");
    model_reset();
    release_reset();
    idle(8);
    check_all_zero("rst_send_after");
    check_counts("rst");
    do_frame(8'h30, 8'h0C, {2'b00, OP_OR}, 0, 1, 0, 0, 0);
    check_eq("fresh_res", o_data_out, 8'h3C);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        abort_frame($urandom_range(1, 2));
      end else begin
        int g1, g2;
        g1 = ($urandom_range(0, 3) == 0) ? T - 1 : $urandom_range(0, T - 1);
        g2 = ($urandom_range(0, 3) == 0) ? T - 1 : $urandom_range(0, T - 1);
        do_frame(8'($urandom), 8'($urandom), {2'($urandom), ops[$urandom_range(0, 7)]},
                 g1, g2, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0));
      end
      check_counts("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
